// File: rtl/tds_link_skew_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tds_link_skew_emulator
// Function : Four synthetic TDS pad-data links with programmable per-link
//            word delay, used to inject known skew ahead of the link aligner.
//            Optional macro TDS_SKEW_EMU_LFSR_EN adds the LFSR payload pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tds_link_skew_emulator #(
    parameter int VALID_PERIOD = 4,
    parameter int BCID_MAX     = 3563
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [1:0]   pattern_sel,
    input  logic [2:0]   skew_0,
    input  logic [2:0]   skew_1,
    input  logic [2:0]   skew_2,
    input  logic [2:0]   skew_3,
    output logic [115:0] pad_data_0,
    output logic [115:0] pad_data_1,
    output logic [115:0] pad_data_2,
    output logic [115:0] pad_data_3,
    output logic         pad_data_valid_0,
    output logic         pad_data_valid_1,
    output logic         pad_data_valid_2,
    output logic         pad_data_valid_3,
    output logic [11:0]  bcid_ref
);

    localparam int              C_NLINK    = 4;
    localparam int              C_NTAP     = 5;
    localparam int              C_DIV_W    = (VALID_PERIOD > 2) ? $clog2(VALID_PERIOD) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(VALID_PERIOD - 1);
    localparam logic [11:0]     C_BCID_MAX = 12'(BCID_MAX);
    localparam logic [6:0]      C_MOD_LAST = 7'd95;

    logic [C_DIV_W-1:0] r_div;
    logic [11:0]        r_bcid;
    logic [6:0]         r_bmod;
    logic [3:0]         r_seq;
    logic               r_pend;
    logic               r_valid;
    logic [11:0]        r_bcid_ref;
    logic [115:0]       r_tap [C_NLINK][C_NTAP];
    logic [115:0]       r_pad [C_NLINK];

    logic               w_strobe;
    logic [31:0]        w_lfsr;
    logic [95:0]        w_payload;
    logic [2:0]         w_skew    [C_NLINK];
    logic [115:0]       w_word    [C_NLINK];
    logic [115:0]       w_tap_sel [C_NLINK];

    assign w_strobe = enable && (r_div == C_DIV_LAST);

    assign w_skew[0] = skew_0;
    assign w_skew[1] = skew_1;
    assign w_skew[2] = skew_2;
    assign w_skew[3] = skew_3;

`ifdef TDS_SKEW_EMU_LFSR_EN
    logic [31:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 32'h0000_0001;
        end else if (w_strobe) begin
            r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
        end
    end

    assign w_lfsr = r_lfsr;
`else
    // Without the LFSR, pattern 11 collapses to an all-zero payload.
    assign w_lfsr = 32'h0000_0000;
`endif

    // r_bmod tracks bcid mod 96 incrementally to avoid a divider.
    always_comb begin
        w_payload = '0;
        case (pattern_sel)
            2'b01:   w_payload = 96'(1) << r_bmod;
            2'b10:   w_payload = {8{r_bcid}};
            2'b11:   w_payload = {3{w_lfsr}};
            default: w_payload = '0;
        endcase
    end

    always_comb begin
        for (int k = 0; k < C_NLINK; k++) begin
            w_word[k] = {r_bcid, 4'(k), r_seq, w_payload};
        end
    end

    // Skew values above 4 clamp to the deepest tap.
    always_comb begin
        for (int k = 0; k < C_NLINK; k++) begin
            case (w_skew[k])
                3'd0:    w_tap_sel[k] = r_tap[k][0];
                3'd1:    w_tap_sel[k] = r_tap[k][1];
                3'd2:    w_tap_sel[k] = r_tap[k][2];
                3'd3:    w_tap_sel[k] = r_tap[k][3];
                default: w_tap_sel[k] = r_tap[k][4];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_bcid     <= '0;
            r_bmod     <= '0;
            r_seq      <= '0;
            r_pend     <= 1'b0;
            r_valid    <= 1'b0;
            r_bcid_ref <= '0;
            for (int k = 0; k < C_NLINK; k++) begin
                r_pad[k] <= '0;
                for (int i = 0; i < C_NTAP; i++) begin
                    r_tap[k][i] <= '0;
                end
            end
        end else begin
            if (!enable || (r_div == C_DIV_LAST)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + C_DIV_W'(1);
            end

            r_pend  <= w_strobe;
            r_valid <= r_pend;

            // Output edge: taps already hold the post-shift view.
            if (r_pend) begin
                for (int k = 0; k < C_NLINK; k++) begin
                    r_pad[k] <= w_tap_sel[k];
                end
            end

            if (w_strobe) begin
                for (int k = 0; k < C_NLINK; k++) begin
                    r_tap[k][0] <= w_word[k];
                    for (int i = 1; i < C_NTAP; i++) begin
                        r_tap[k][i] <= r_tap[k][i-1];
                    end
                end
                r_bcid_ref <= r_bcid;
                r_seq      <= r_seq + 4'd1;
                if (r_bcid == C_BCID_MAX) begin
                    r_bcid <= '0;
                    r_bmod <= '0;
                end else begin
                    r_bcid <= r_bcid + 12'd1;
                    r_bmod <= (r_bmod == C_MOD_LAST) ? 7'd0 : r_bmod + 7'd1;
                end
            end
        end
    end

    assign pad_data_0       = r_pad[0];
    assign pad_data_1       = r_pad[1];
    assign pad_data_2       = r_pad[2];
    assign pad_data_3       = r_pad[3];
    assign pad_data_valid_0 = r_valid;
    assign pad_data_valid_1 = r_valid;
    assign pad_data_valid_2 = r_valid;
    assign pad_data_valid_3 = r_valid;
    assign bcid_ref         = r_bcid_ref;

endmodule
`default_nettype wire

// File: tb/tb_tds_link_skew_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tds_link_skew_emulator
// Function : Self-checking bench for tds_link_skew_emulator against a
//            word-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tds_link_skew_emulator;

    localparam int VP   = 4;
    localparam int BMAX = 3563;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [1:0]   pattern_sel;
    logic [2:0]   skew [4];
    logic [115:0] pad  [4];
    logic         vld  [4];
    logic [11:0]  bcid_ref;

    int n_pass  = 0;
    int n_total = 0;
    int gen_n   = 0;

    logic [1:0]  pat_hist  [8192];
    logic [31:0] lfsr_hist [8192];

    always #5 clk = ~clk;

    tds_link_skew_emulator #(.VALID_PERIOD(VP), .BCID_MAX(BMAX)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .pattern_sel      (pattern_sel),
        .skew_0           (skew[0]),
        .skew_1           (skew[1]),
        .skew_2           (skew[2]),
        .skew_3           (skew[3]),
        .pad_data_0       (pad[0]),
        .pad_data_1       (pad[1]),
        .pad_data_2       (pad[2]),
        .pad_data_3       (pad[3]),
        .pad_data_valid_0 (vld[0]),
        .pad_data_valid_1 (vld[1]),
        .pad_data_valid_2 (vld[2]),
        .pad_data_valid_3 (vld[3]),
        .bcid_ref         (bcid_ref)
    );

    // Expected word for generation index n on link k; negative n is a reset-zero tap.
    function automatic logic [115:0] exp_word(input int n, input int k);
        int          b;
        logic [95:0] pl;
        logic [11:0] b12;
        if (n < 0) return '0;
        b   = n % (BMAX + 1);
        b12 = 12'(b);
        pl  = '0;
        case (pat_hist[n])
            2'd1: pl = 96'(1) << (b % 96);
            2'd2: pl = {8{b12}};
`ifdef TDS_SKEW_EMU_LFSR_EN
            2'd3: pl = {3{lfsr_hist[n]}};
`endif
            default: pl = '0;
        endcase
        return {b12, 4'(k), 4'(n % 16), pl};
    endfunction

    function automatic int clamp(input logic [2:0] s);
        return (s > 3'd4) ? 4 : int'(s);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next valid and check the word against the model.
    task automatic step(input int exp_cycles);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!vld[0] && c < 20);
        check("valid_interval", 128'(c), 128'(exp_cycles));
        pat_hist[gen_n] = pattern_sel;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("valid_%0d", k), 128'(vld[k]), 128'(1));
            check($sformatf("pad_w%0d_l%0d", gen_n, k), 128'(pad[k]),
                  128'(exp_word(gen_n - clamp(skew[k]), k)));
        end
        check("bcid_ref", 128'(bcid_ref), 128'(gen_n % (BMAX + 1)));
        gen_n++;
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_pad"}, 128'(pad[k]), 128'(0));
            check({tag, "_valid"}, 128'(vld[k]), 128'(0));
        end
        check({tag, "_bcid_ref"}, 128'(bcid_ref), 128'(0));
    endtask

    initial begin
        lfsr_hist[0] = 32'h0000_0001;
        for (int i = 1; i < 8192; i++) begin
            lfsr_hist[i] = {lfsr_hist[i-1][30:0],
                            lfsr_hist[i-1][31] ^ lfsr_hist[i-1][21] ^ lfsr_hist[i-1][1] ^ lfsr_hist[i-1][0]};
        end

        // Reset with pattern 10, skews 0
        rst_n       = 1'b0;
        enable      = 1'b1;
        pattern_sel = 2'b10;
        for (int k = 0; k < 4; k++) skew[k] = 3'd0;
        tick();
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        gen_n = 0;
        step(VP + 1);
        for (int i = 0; i < 7; i++) step(VP);

        // Skews 0,1,2,4: link 0 reaching BCID 10 shows 9,8,6 on links 1..3
        skew[1] = 3'd1;
        skew[2] = 3'd2;
        skew[3] = 3'd4;
        while (gen_n <= 12) step(VP);

        // Clamp: skew 7 behaves as 4
        skew[2] = 3'd7;
        while (gen_n <= 20) begin
            step(VP);
            pattern_sel = 2'($urandom_range(0, 3));
        end

        // Enable drop after BCID 20
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("disabled_valid", 128'(vld[0]), 128'(0));
            check("disabled_pad0", 128'(pad[0]), 128'(exp_word(gen_n - 1 - clamp(skew[0]), 0)));
            check("disabled_bcid_ref", 128'(bcid_ref), 128'(gen_n - 1));
        end
        enable = 1'b1;
        step(VP + 1);

        // Randomized pattern/skew run through BCID wrap
        while (gen_n < BMAX + 8) begin
            step(VP);
            pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++) skew[k] = 3'($urandom_range(0, 7));
            end
        end

        // Mid-word reset
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        tick();
        check_idle_zero("midreset_hold");
        pattern_sel = 2'b11;
        skew[0] = 3'd0;
        skew[1] = 3'd1;
        skew[2] = 3'd2;
        skew[3] = 3'd4;
        rst_n = 1'b1;
        gen_n = 0;
        step(VP + 1);
        for (int i = 0; i < 8; i++) begin
            step(VP);
            pattern_sel = 2'($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tds_link_skew_emulator.md
# tds_link_skew_emulator

Generates four synthetic TDS pad-data links (116-bit words, BCID in [115:104]) with a programmable per-link word delay, to drive the link latency alignment stage in lab and simulation without front-end hardware. It is the transmit-side counterpart of the aligner: it injects known inter-link skew that the aligner must remove. It sits in the trigger_info_generator test path, muxed in place of the real TDS deserializer outputs.

## Interface

Parameters:
- VALID_PERIOD, 4: clk cycles per generated word (≥2).
- BCID_MAX, 3563: last BCID before wrap to 0.

Ports:
- clk  input  1  single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  run generator; low freezes it.
- pattern_sel  input  2  payload pattern: 00 zeros, 01 walking one, 10 replicated BCID, 11 LFSR.
- skew_0 … skew_3  input  3 each  per-link delay in words, 0–4; values 5–7 clamp to 4.
- pad_data_0 … pad_data_3  output  116 each  link words.
- pad_data_valid_0 … pad_data_valid_3  output  1 each  word strobes.
- bcid_ref  output  12  BCID of the most recently generated, undelayed word.

## Operation

- Divider counts 0..VALID_PERIOD-1 while enable=1; held at 0 while enable=0. Strobe = enable && div==VALID_PERIOD-1.
- Word W(b,k): [115:104]=b; [103:100]=k; [99:96]=seq[3:0] (word counter, +1 per strobe, wraps); [95:0] payload:
  - 00: all zero. 01: only bit (b mod 96) set. 10: {8{b}}. 11: {3{lfsr}}.
- lfsr: 32-bit Fibonacci, seed 32'h0000_0001, per strobe lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
- On strobe edge: per link k, tap_k[0] <= W(bcid,k), tap_k[i] <= tap_k[i-1] for i=1..4; bcid <= (bcid==BCID_MAX) ? 0 : bcid+1; bcid_ref <= bcid; seq and lfsr advance.
- Edge after strobe: pad_data_k <= tap_k[min(skew_k,4)] (post-shift); all four pad_data_valid_k high for exactly one cycle, simultaneously.
- skew_k sampled at the output-register edge; change mid-run takes effect on next word, no flush; words may repeat or be skipped at the change.
- Delay-line taps reset to all-zero; after reset, a link with skew s outputs s all-zero words (BCID 0, link id 0) before real data.
- enable falling: no further strobes; outputs, taps, bcid, lfsr hold; valids low. Re-enable resumes from held state, first strobe VALID_PERIOD cycles later.

## Timing

- Reset (async assert, sync-free release): pad_data_k=0, pad_data_valid_k=0, bcid_ref=0, bcid=0, seq=0, div=0, lfsr=1, taps=0.
- First strobe edge at the VALID_PERIOD-th rising edge with enable=1 after reset release; first valid the following cycle.
- Latency: word generated at strobe n appears on link k with the valid following strobe n+skew_k, i.e. 1 + skew_k·VALID_PERIOD cycles after its generation edge.
- Valid duty: 1 cycle in VALID_PERIOD.
- Reset asserted mid-word: all state clears immediately; no partial valid.

## Configuration

- TDS_SKEW_EMU_LFSR_EN defined: LFSR register and pattern 11 implemented as above.
- Undefined: no LFSR register; pattern 11 behaves as 00 (payload zero). All other behaviour unchanged.

## Test plan

- Reset release, enable=1, VALID_PERIOD=4, skews 0, pattern 10 -> valids every 4 cycles on all links, BCIDs 0,1,2…, payload {8{BCID}}, link id field 0–3.
- Skews 0,1,2,4 after ≥5 words -> at the valid where link 0 shows BCID 10, links 1–3 show 9, 8, 6; first 1/2/4 words on links 1/2/3 are all-zero.
- Run across wrap with BCID_MAX=3563 -> link 0 sequence …3562, 3563, 0, 1; bcid_ref matches undelayed BCID; seq field wraps 15->0.
- skew_2=7 -> link 2 identical to skew_2=4.
- Drop enable for 10 cycles after BCID 20 -> no valids, outputs held; re-enable -> next word BCID 21 after 4 cycles.
- Assert rst_n low mid-run -> all outputs 0 within the same cycle, no valid; with TDS_SKEW_EMU_LFSR_EN and pattern 11, first word after reset payload {3{32'h0000_0001}}.
